// File: rtl/lift_scheduler.sv
// lift_scheduler: SCAN (collective) lift controller with per-floor travel timer and timed door dwell.
// Define LIFT_EMERGENCY_EN to add the estop input that freezes motion while asserted.
module lift_scheduler #(
    parameter int  NUM_FLOORS    = 8,
    parameter int  TRAVEL_CYCLES = 8,
    parameter int  DOOR_CYCLES   = 16,
    localparam int FLOOR_W       = ($clog2(NUM_FLOORS) > 0) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  door_hold,
`ifdef LIFT_EMERGENCY_EN
    input  logic                  estop,
`endif
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);
    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LD   = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d, next_fl;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  dir_q, dir_d, frz;
    logic [NUM_FLOORS-1:0] pend_q, pend_d, pend_n, clr, hot_q, hot_d;

`ifdef LIFT_EMERGENCY_EN
    assign frz = estop;
`else
    assign frz = 1'b0;
`endif

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        return |((p >> f) >> 1);
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        return |(p & ~({NUM_FLOORS{1'b1}} << f));
    endfunction

    // Arrival decisions also see calls arriving on the arrival edge itself.
    assign pend_n  = pend_q | call_req;
    assign next_fl = (state_q == MOVE_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
    assign hot_q   = NUM_FLOORS'(1) << floor_q;
    assign hot_d   = NUM_FLOORS'(1) << floor_d;

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pend_q[floor_q]) begin
                    state_d = DOOR_OPEN;
                    cnt_d   = DOOR_LD;
                end else if (any_above(pend_q, floor_q) && (dir_q || !any_below(pend_q, floor_q))) begin
                    state_d = MOVE_UP;
                    dir_d   = 1'b1;
                    cnt_d   = TRAVEL_LD;
                end else if (any_below(pend_q, floor_q)) begin
                    state_d = MOVE_DOWN;
                    dir_d   = 1'b0;
                    cnt_d   = TRAVEL_LD;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    floor_d = next_fl;
                    cnt_d   = TRAVEL_LD;
                    if (pend_n[next_fl]) begin
                        state_d = DOOR_OPEN;
                        cnt_d   = DOOR_LD;
                    end else if (!((state_q == MOVE_UP) ? any_above(pend_n, next_fl) : any_below(pend_n, next_fl))) begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                cnt_d = cnt_q - 1'b1;
                if (door_hold || call_req[floor_q]) cnt_d = DOOR_LD;
                else if (cnt_q == '0) state_d = IDLE;
            end
            default: ;
        endcase
        if (frz) begin
            state_d = state_q;
            floor_d = floor_q;
            dir_d   = dir_q;
            cnt_d   = cnt_q;
        end
        // The landing call is absorbed as the door opens; calls at an open door only extend the dwell.
        clr    = (state_d == DOOR_OPEN && state_q != DOOR_OPEN) ? hot_d : '0;
        pend_d = pend_n & ~clr & ~((state_q == DOOR_OPEN) ? hot_q : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            floor_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
        end
    end

    assign current_floor = floor_q;
    assign motor_up      = (state_q == MOVE_UP) && !frz;
    assign motor_down    = (state_q == MOVE_DOWN) && !frz;
    assign door_open     = (state_q == DOOR_OPEN);
    assign dir_up        = dir_q;
    assign pending       = pend_q;
    assign busy          = (state_q != IDLE) || (|pend_q);
endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed scenarios for lift_scheduler checked every cycle against a
// procedural trip model, plus literal timing/ordering expectations per scenario.
module tb_lift_scheduler;
    localparam int N = 8, T = 4, D = 3;
    localparam int IDL = 0, UP = 1, DN = 2, DR = 3;

    logic         clk = 1'b0, reset_n = 1'b0, door_hold = 1'b0, estop = 1'b0;
    logic [N-1:0] call_req = '0;
    logic [2:0]   current_floor;
    logic         motor_up, motor_down, door_open, dir_up, busy;
    logic [N-1:0] pending;

    lift_scheduler #(.NUM_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n), .call_req(call_req), .door_hold(door_hold),
`ifdef LIFT_EMERGENCY_EN
        .estop(estop),
`endif
        .current_floor(current_floor), .motor_up(motor_up), .motor_down(motor_down),
        .door_open(door_open), .dir_up(dir_up), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a trip-level process (idle decision, floor-by-floor travel, door dwell).
    int           m_floor, m_mode;
    bit           m_dir, m_abort;
    logic [N-1:0] m_pend;

    function automatic logic [N-1:0] hot(input int f);
        logic [N-1:0] h = '0;
        h[f] = 1'b1;
        return h;
    endfunction

    function automatic bit ahead(input logic [N-1:0] p, input int f, input bit up);
        for (int i = 0; i < N; i++) if (p[i] && (up ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_floor = 0; m_dir = 1'b1; m_mode = IDL; m_pend = '0; m_abort = 1'b1;
    endtask

    task automatic latch(input logic [N-1:0] clr);
        m_pend = (m_pend | call_req) & ~clr & ~((m_mode == DR) ? hot(m_floor) : '0);
    endtask

    // Returns on the next edge that is allowed to make progress; frozen edges only latch calls.
    task automatic edge_wait();
        forever begin
            @(posedge clk);
            if (m_abort || !estop) return;
            latch('0);
        end
    endtask

    task automatic m_dwell();
        int quiet = 0;
        while (quiet < D) begin
            edge_wait();
            if (m_abort) return;
            if (door_hold || call_req[m_floor]) quiet = 0; else quiet++;
            latch('0);
        end
        m_mode = IDL;
    endtask

    task automatic m_move(input bit up);
        int f;
        latch('0);
        m_dir = up; m_mode = up ? UP : DN;
        forever begin
            repeat (T - 1) begin
                edge_wait();
                if (m_abort) return;
                latch('0);
            end
            edge_wait();
            if (m_abort) return;
            f = m_floor + (up ? 1 : -1);
            m_floor = f;
            if (m_pend[f] || call_req[f]) begin
                latch(hot(f));
                m_mode = DR;
                m_dwell();
                return;
            end
            latch('0);
            if (!ahead(m_pend, f, up)) begin
                m_mode = IDL;
                return;
            end
        end
    endtask

    task automatic m_idle();
        edge_wait();
        if (m_abort) return;
        if (m_pend[m_floor]) begin
            latch(hot(m_floor));
            m_mode = DR;
            m_dwell();
        end else if (m_dir && ahead(m_pend, m_floor, 1)) m_move(1);
        else if (ahead(m_pend, m_floor, 0)) m_move(0);
        else if (ahead(m_pend, m_floor, 1)) m_move(1);
        else latch('0);
    endtask

    initial begin
        m_reset();
        forever begin
            wait (reset_n);
            m_abort = 1'b0;
            while (!m_abort) m_idle();
        end
    end

    always @(negedge reset_n) m_reset();

    initial forever begin
        @(posedge clk);
        #1;
        chk("floor", current_floor, m_floor);
        chk("motor_up", motor_up, (m_mode == UP) && !estop);
        chk("motor_down", motor_down, (m_mode == DN) && !estop);
        chk("door_open", door_open, m_mode == DR);
        chk("dir_up", dir_up, m_dir);
        chk("pending", pending, m_pend);
        chk("busy", busy, (m_mode != IDL) || (m_pend != '0));
    end

    // Stimulus helpers, all driven from the falling edge.
    task automatic do_reset();
        reset_n = 1'b0; call_req = '0; door_hold = 1'b0; estop = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        call_req = v;
        @(negedge clk);
        call_req = '0;
    endtask

    int w_up, w_dn, w_door, w_idle, w_first, w_nd;
    int w_fl[4];
    task automatic watch(input int maxc);
        bit pd = 1'b0;
        w_up = 0; w_dn = 0; w_door = 0; w_idle = 0; w_first = -1; w_nd = 0;
        for (int i = 0; i < maxc; i++) begin
            if (motor_up) w_up++;
            if (motor_down) w_dn++;
            if (door_open) begin
                w_door++;
                if (!pd && w_nd < 4) begin w_fl[w_nd] = int'(current_floor); w_nd++; end
                if (w_first < 0) w_first = i;
            end
            if (busy && !motor_up && !motor_down && !door_open) w_idle++;
            pd = door_open;
            if (!busy) break;
            @(negedge clk);
        end
        chk("watch_settled", busy, 0);
    endtask

    int c_door, c_mot, arr;

    initial begin
        do_reset();
        chk("rst_floor", current_floor, 0);
        chk("rst_dir", dir_up, 1);
        chk("rst_busy", busy, 0);

        // 1: single call to floor 3
        pulse(8'h08);
        watch(100);
        chk("t1_up", w_up, 12);
        chk("t1_door", w_door, 3);
        chk("t1_ndoor", w_nd, 1);
        chk("t1_floor", w_fl[0], 3);
        chk("t1_first_door", w_first, 13);
        chk("t1_idle", w_idle, 1);

        // 2: at floor 2 heading up, calls at 0 and 5 together
        do_reset();
        pulse(8'h04);
        watch(100);
        chk("t2_start", current_floor, 2);
        pulse(8'h21);
        watch(200);
        chk("t2_ndoor", w_nd, 2);
        chk("t2_first", w_fl[0], 5);
        chk("t2_second", w_fl[1], 0);
        chk("t2_up", w_up, 12);
        chk("t2_dn", w_dn, 20);
        chk("t2_idle", w_idle, 2);
        chk("t2_dir", dir_up, 0);

        // 3: intermediate call picked up on the way
        do_reset();
        pulse(8'h40);
        for (int i = 0; i < 100 && current_floor != 2; i++) @(negedge clk);
        chk("t3_at2", current_floor, 2);
        pulse(8'h10);
        watch(200);
        chk("t3_ndoor", w_nd, 2);
        chk("t3_first", w_fl[0], 4);
        chk("t3_second", w_fl[1], 6);
        chk("t3_up", w_up, 15);
        chk("t3_door", w_door, 6);
        chk("t3_idle", w_idle, 1);

        // 5: reset while moving down from 6 toward 0
        pulse(8'h01);
        for (int i = 0; i < 100 && current_floor != 5; i++) @(negedge clk);
        chk("t5_moving", motor_down, 1);
        chk("t5_pend", pending, 8'h01);
        reset_n = 1'b0;
        #1;
        chk("t5_mdn", motor_down, 0);
        chk("t5_mup", motor_up, 0);
        chk("t5_door", door_open, 0);
        chk("t5_floor", current_floor, 0);
        chk("t5_pending", pending, 0);
        chk("t5_dir", dir_up, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 4: call at current floor, door hold, repeat call at open door
        pulse(8'h01);
        c_door = 0; c_mot = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (door_open) c_door++;
            if (motor_up || motor_down) c_mot++;
            door_hold = (i < 5);
            call_req = (i == 2) ? 8'h01 : 8'h00;
        end
        chk("t4_door", c_door, 8);
        chk("t4_motor", c_mot, 0);
        chk("t4_pending", pending, 0);
        chk("t4_busy", busy, 0);

`ifdef LIFT_EMERGENCY_EN
        // 6: estop for 10 cycles mid-travel delays arrival by exactly 10 cycles
        do_reset();
        pulse(8'h08);
        arr = -1;
        for (int i = 0; i < 60; i++) begin
            if (door_open) begin arr = i; break; end
            if (estop) chk("t6_motor", motor_up, 0);
            if (i == 5) estop = 1'b1;
            if (i == 15) estop = 1'b0;
            @(negedge clk);
        end
        chk("t6_arrival", arr, 23);
        watch(50);
        chk("t6_floor", current_floor, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
